// File: rtl/coin_pkg.sv
// Shared definitions for the coin accumulator: per-channel coin values,
// debounce FSM states and the one-hot helper.
package coin_pkg;

  // Channels beyond NUM_COINS are ignored; NUM_COINS must not exceed MAX_COINS.
  localparam int MAX_COINS = 8;
  localparam int COIN_VAL [MAX_COINS] = '{1, 2, 5, 10, 20, 50, 100, 200};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    JUDGE,
    WAIT_REL
  } coin_state_t;

  function automatic logic is_onehot(input logic [MAX_COINS-1:0] code);
    return (code != '0) && ((code & (code - MAX_COINS'(1))) == '0);
  endfunction

endpackage

// File: rtl/coin_accumulator_if.sv
// Bundle of the coin sensor bus, coin result outputs and the spend/refund
// handshakes between the vending control logic and the coin accumulator.
interface coin_accumulator_if #(
  parameter int NUM_COINS = 4,
  parameter int CREDIT_W  = 8
);
  logic [NUM_COINS-1:0] coin_code;
  logic                 coin_valid;
  logic [CREDIT_W-1:0]  coin_value;
  logic                 coin_reject;
  logic [CREDIT_W-1:0]  credit;
  logic                 spend_req;
  logic [CREDIT_W-1:0]  spend_amt;
  logic                 spend_ack;
  logic                 spend_nak;
  logic                 refund_req;
  logic                 refund_valid;
  logic [CREDIT_W-1:0]  refund_value;

  modport master (
    output coin_code, spend_req, spend_amt, refund_req,
    input  coin_valid, coin_value, coin_reject, credit,
           spend_ack, spend_nak, refund_valid, refund_value
  );

  modport slave (
    input  coin_code, spend_req, spend_amt, refund_req,
    output coin_valid, coin_value, coin_reject, credit,
           spend_ack, spend_nak, refund_valid, refund_value
  );
endinterface

// File: rtl/coin_debounce.sv
// Debounces the one-hot coin sensor bus and emits a single judge strobe,
// together with the settled code, once per coin insertion.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int NUM_COINS    = 4,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_COINS-1:0] code,
  output logic                 judge,
  output logic [NUM_COINS-1:0] code_lat
);

  localparam int CNT_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  coin_state_t          state, state_nx;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic [NUM_COINS-1:0] lat_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      code_lat <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      code_lat <= lat_nx;
    end
  end

  // Once the count is reached the coin is judged even if the code moves on;
  // WAIT_REL then blocks any second coin until the bus has gone idle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat_nx   = code_lat;
    case (state)
      IDLE: begin
        if (code != '0) begin
          lat_nx   = code;
          cnt_nx   = CNT_ONE;
          state_nx = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == CNT_DONE) begin
          state_nx = JUDGE;
        end else if (code == '0) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else if (code == code_lat) begin
          cnt_nx = cnt + CNT_ONE;
        end else begin
          lat_nx = code;
          cnt_nx = CNT_ONE;
        end
      end
      JUDGE: begin
        cnt_nx   = '0;
        state_nx = WAIT_REL;
      end
      WAIT_REL: begin
        if (code == '0) begin
          state_nx = IDLE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  assign judge = (state == JUDGE);

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: debounced coin acceptance, saturation-checked credit and
// spend/refund handshakes. Define COIN_STATS_EN to add per-channel coin counters.
module coin_accumulator
  import coin_pkg::*;
#(
  parameter int NUM_COINS    = 4,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 99,
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  coin_accumulator_if.slave bus
`ifdef COIN_STATS_EN
  ,
  output logic [NUM_COINS*16-1:0] coin_count
`endif
);

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W + 1)'(MAX_CREDIT);

  logic                 judge;
  logic [NUM_COINS-1:0] code_lat;
  logic [CREDIT_W-1:0]  credit_q, credit_nx;
  logic [CREDIT_W-1:0]  val, add_amt, sub_amt;
  logic [CREDIT_W:0]    sum;
  logic                 onehot, fits, accept, reject, spend_ok, spend_bad;

  coin_debounce #(
    .NUM_COINS    (NUM_COINS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .code     (bus.coin_code),
    .judge    (judge),
    .code_lat (code_lat)
  );

  // Spend and refund are judged against the registered credit, so a coin
  // landing in the same cycle can neither fund a spend nor be refunded.
  always_comb begin
    val = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (code_lat[i]) val = CREDIT_W'(COIN_VAL[i]);
    end
    onehot    = is_onehot(MAX_COINS'(code_lat));
    sum       = {1'b0, credit_q} + {1'b0, val};
    fits      = (sum <= MAX_SUM);
    accept    = judge && onehot && fits;
    reject    = judge && !(onehot && fits);
    spend_ok  = bus.spend_req && !bus.refund_req && (bus.spend_amt <= credit_q);
    spend_bad = bus.spend_req && !spend_ok;
    add_amt   = accept ? val : '0;
    sub_amt   = spend_ok ? bus.spend_amt : '0;
    credit_nx = bus.refund_req ? add_amt : (credit_q + add_amt - sub_amt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q         <= '0;
      bus.coin_valid   <= 1'b0;
      bus.coin_reject  <= 1'b0;
      bus.coin_value   <= '0;
      bus.spend_ack    <= 1'b0;
      bus.spend_nak    <= 1'b0;
      bus.refund_valid <= 1'b0;
      bus.refund_value <= '0;
    end else begin
      credit_q         <= credit_nx;
      bus.coin_valid   <= accept;
      bus.coin_reject  <= reject;
      if (accept) bus.coin_value <= val;
      bus.spend_ack    <= spend_ok;
      bus.spend_nak    <= spend_bad;
      bus.refund_valid <= bus.refund_req;
      bus.refund_value <= bus.refund_req ? credit_q : '0;
    end
  end

  assign bus.credit = credit_q;

`ifdef COIN_STATS_EN
  // Only accepted coins are counted; each 16-bit counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      coin_count <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (code_lat[i]) coin_count[i*16 +: 16] <= coin_count[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed steps push expected pulse
// records to a scoreboard that a negedge monitor pops and compares.
module tb_coin_accumulator;
  import coin_pkg::*;

  localparam int DEB = 4;
  localparam int MAXC = 99;
  localparam int VAL [4] = '{1, 2, 5, 10};

  typedef struct {
    int         at;
    logic [4:0] mask;
    int         cval;
    int         rval;
    int         credit;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_no = 0;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  int   credit_m = 0;
  int   cval_m = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [4:0] obs_mask;

  coin_accumulator_if #(.NUM_COINS(4), .CREDIT_W(8)) bus ();

`ifdef COIN_STATS_EN
  logic [63:0] coin_count;
  int stats_m [4] = '{0, 0, 0, 0};
`endif

  coin_accumulator #(
    .NUM_COINS    (4),
    .CREDIT_W     (8),
    .MAX_CREDIT   (MAXC),
    .DEBOUNCE_CYC (DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef COIN_STATS_EN
    ,
    .coin_count (coin_count)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_no <= edge_no + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] code, input bit sreq, input int amt, input bit rreq);
    bus.coin_code  = code;
    bus.spend_req  = sreq;
    bus.spend_amt  = 8'(amt);
    bus.refund_req = rreq;
    @(negedge clk);
  endtask

  // Reference model for one clock edge: optional coin judgement plus optional spend/refund.
  task automatic predict(input int at, input logic [3:0] code, input bit sreq, input int amt, input bit rreq);
    exp_t x;
    int   val = 0;
    int   idx = 0;
    bit   acc = 1'b0;
    int   nc;
    x.at = at;
    x.mask = '0;
    x.rval = 0;
    if (code != 4'b0) begin
      if ($onehot(code)) begin
        for (int i = 0; i < 4; i++) if (code[i]) begin val = VAL[i]; idx = i; end
        acc = (credit_m + val <= MAXC);
      end
      x.mask[4] = acc;
      x.mask[3] = !acc;
    end
    nc = credit_m + (acc ? val : 0);
    if (rreq) begin
      x.mask[0] = 1'b1;
      x.mask[1] = sreq;
      x.rval = credit_m;
      nc = acc ? val : 0;
    end else if (sreq) begin
      if (amt <= credit_m) begin
        x.mask[2] = 1'b1;
        nc = nc - amt;
      end else begin
        x.mask[1] = 1'b1;
      end
    end
    if (acc) begin
      cval_m = val;
`ifdef COIN_STATS_EN
      stats_m[idx]++;
`endif
    end
    credit_m = nc;
    x.credit = nc;
    x.cval = cval_m;
    if (x.mask != 5'b0) sb.push_back(x);
  endtask

  task automatic insertCoin(input logic [3:0] code, input int hold, input bit sreq, input int amt, input bit rreq);
    predict(edge_no + DEB + 2, code, sreq, amt, rreq);
    for (int i = 0; i < hold; i++) begin
      if (i == DEB + 1) applyStimulus(code, sreq, amt, rreq);
      else applyStimulus(code, 1'b0, 0, 1'b0);
    end
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic doOp(input bit sreq, input int amt, input bit rreq);
    predict(edge_no + 1, 4'b0, sreq, amt, rreq);
    applyStimulus(4'b0, sreq, amt, rreq);
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic resetModel();
    credit_m = 0;
    cval_m = 0;
`ifdef COIN_STATS_EN
    for (int i = 0; i < 4; i++) stats_m[i] = 0;
`endif
  endtask

  task automatic checkStats();
`ifdef COIN_STATS_EN
    for (int i = 0; i < 4; i++) checkOutput($sformatf("coin_count_%0d", i), 32'(coin_count[i*16 +: 16]), stats_m[i]);
`endif
  endtask

  // Every pulse cycle must match the oldest pending expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      obs_mask = {bus.coin_valid, bus.coin_reject, bus.spend_ack, bus.spend_nak, bus.refund_valid};
      if (obs_mask !== 5'b0) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", 32'(obs_mask), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("pulse_edge", edge_no, mon_e.at);
          checkOutput("pulse_kind", 32'(obs_mask), 32'(mon_e.mask));
          checkOutput("pulse_credit", 32'(bus.credit), mon_e.credit);
          if (mon_e.mask[4]) checkOutput("coin_value", 32'(bus.coin_value), mon_e.cval);
          if (mon_e.mask[0]) checkOutput("refund_value", 32'(bus.refund_value), mon_e.rval);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.coin_code  = 4'b0;
    bus.spend_req  = 1'b0;
    bus.spend_amt  = 8'd0;
    bus.refund_req = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_credit", 32'(bus.credit), 0);
    checkOutput("rst_coin_valid", 32'(bus.coin_valid), 0);
    checkOutput("rst_coin_reject", 32'(bus.coin_reject), 0);
    checkOutput("rst_coin_value", 32'(bus.coin_value), 0);
    checkOutput("rst_spend_ack", 32'(bus.spend_ack), 0);
    checkOutput("rst_spend_nak", 32'(bus.spend_nak), 0);
    checkOutput("rst_refund_valid", 32'(bus.refund_valid), 0);
    checkOutput("rst_refund_value", 32'(bus.refund_value), 0);
    checkStats();
    rst = 1'b0;
    mon_en = 1'b1;

    // Single 5-coin held six cycles: one accept at k+DEB+1.
    insertCoin(4'b0100, 6, 1'b0, 0, 1'b0);
    checkOutput("t1_credit", 32'(bus.credit), 5);
    checkStats();

    // Partial 2-coin then stable 1-coin: only the 1-coin counts.
    predict(edge_no + 2 + DEB + 2, 4'b0001, 1'b0, 0, 1'b0);
    repeat (2) applyStimulus(4'b0010, 1'b0, 0, 1'b0);
    repeat (5) applyStimulus(4'b0001, 1'b0, 0, 1'b0);
    repeat (2) applyStimulus(4'b0000, 1'b0, 0, 1'b0);
    checkOutput("t2_credit", 32'(bus.credit), 6);

    // Build to 95, then overflow reject and the exact-limit boundary.
    repeat (8) insertCoin(4'b1000, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0100, 6, 1'b0, 0, 1'b0);
    repeat (2) insertCoin(4'b0010, 6, 1'b0, 0, 1'b0);
    checkOutput("t3_credit95", 32'(bus.credit), 95);
    insertCoin(4'b1000, 6, 1'b0, 0, 1'b0);
    checkOutput("t3_after_reject", 32'(bus.credit), 95);
    insertCoin(4'b0010, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0010, 6, 1'b0, 0, 1'b0);
    checkOutput("t3_at_max", 32'(bus.credit), 99);
    insertCoin(4'b0001, 6, 1'b0, 0, 1'b0);
    checkOutput("t3_over_max", 32'(bus.credit), 99);

    // Spend handshakes, including zero amount and same-cycle coin accept.
    doOp(1'b1, 92, 1'b0);
    doOp(1'b1, 8, 1'b0);
    doOp(1'b1, 7, 1'b0);
    doOp(1'b1, 0, 1'b0);
    checkOutput("t4_credit0", 32'(bus.credit), 0);
    insertCoin(4'b0001, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0010, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0010, 6, 1'b1, 3, 1'b0);
    checkOutput("t4_coin_spend", 32'(bus.credit), 2);
    insertCoin(4'b0010, 6, 1'b1, 3, 1'b0);
    checkOutput("t4_coin_nak", 32'(bus.credit), 4);

    // Refund beats spend; a same-cycle coin survives a refund.
    doOp(1'b1, 4, 1'b0);
    insertCoin(4'b1000, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0010, 6, 1'b0, 0, 1'b0);
    doOp(1'b1, 5, 1'b1);
    checkOutput("t5_credit0", 32'(bus.credit), 0);
    insertCoin(4'b0001, 6, 1'b0, 0, 1'b0);
    insertCoin(4'b0100, 6, 1'b0, 0, 1'b1);
    checkOutput("t5_coin_refund", 32'(bus.credit), 5);

    // A held spend_req is a fresh request every cycle.
    for (int i = 0; i < 3; i++) begin
      predict(edge_no + 1, 4'b0, 1'b1, 2, 1'b0);
      applyStimulus(4'b0, 1'b1, 2, 1'b0);
    end
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
    checkOutput("held_spend_credit", 32'(bus.credit), 1);

    // Multi-hot held long: exactly one reject.
    insertCoin(4'b0110, 15, 1'b0, 0, 1'b0);
    checkOutput("t6_multihot_credit", 32'(bus.credit), 1);
    checkStats();

    // Reset while settling discards the coin.
    repeat (3) applyStimulus(4'b0100, 1'b0, 0, 1'b0);
    rst = 1'b1;
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    resetModel();
    repeat (8) applyStimulus(4'b0, 1'b0, 0, 1'b0);
    checkOutput("rst_settle_credit", 32'(bus.credit), 0);
    checkOutput("rst_settle_value", 32'(bus.coin_value), 0);

    // Reset while judging also discards the coin.
    insertCoin(4'b0100, 6, 1'b0, 0, 1'b0);
    checkOutput("pre_judge_rst_credit", 32'(bus.credit), 5);
    repeat (5) applyStimulus(4'b0100, 1'b0, 0, 1'b0);
    rst = 1'b1;
    applyStimulus(4'b0, 1'b0, 0, 1'b0);
    rst = 1'b0;
    resetModel();
    repeat (8) applyStimulus(4'b0, 1'b0, 0, 1'b0);
    checkOutput("rst_judge_credit", 32'(bus.credit), 0);
    checkStats();

    repeat (3) applyStimulus(4'b0, 1'b0, 0, 1'b0);
    checkOutput("scoreboard_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
